// File: rtl/shared_timer_pkg.sv
// Shared definitions for the shared delay timer: FSM state encoding and a
// constant-width helper used to size the round-robin pointer.
package shared_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int width;
        int rest;
        width = 0;
        rest  = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rest > 0) begin
                width++;
                rest = rest >> 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward
// from ptr_i with wrap-around.
module rr_arbiter
    import shared_timer_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    int   j;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_i) + i) % NREQ;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                valid_o    = 1'b1;
                idx_o      = PTR_W'(j);
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_timer_arbiter.sv
// One prescaled delay timer shared round-robin among NREQ requesters; the
// owner is granted, timed for delay*DIVISOR cycles and then pulsed done.
module shared_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DIVISOR = 50000,
    parameter int PRE_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] delay,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  tick
);

    localparam int               PTR_W    = clog2(NREQ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIVISOR - 1);

    state_e             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               busy_q;
    logic               tick_q, tick_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   own_q, own_d;

    logic [NREQ-1:0]    win_onehot;
    logic [PTR_W-1:0]   win_idx;
    logic               win_valid;
    logic [CNT_W-1:0]   win_delay;
    logic [PTR_W-1:0]   next_ptr;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (win_onehot),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign win_delay = delay[int'(win_idx)*CNT_W +: CNT_W];
    assign next_ptr  = (own_q == PTR_W'(NREQ - 1)) ? '0 : own_q + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        tick_d  = 1'b0;
        pre_d   = pre_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_onehot;
                    own_d   = win_idx;
                    rem_d   = win_delay;
                    pre_d   = '0;
                    state_d = (win_delay == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[own_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = grant_q;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            DONE: begin
                // A zero-delay job enters DONE with done low; it spends one
                // extra cycle here so done still trails grant by one cycle.
                if (done_q == '0) begin
                    done_d = grant_q;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            pre_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= |grant_d;
            tick_q  <= tick_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a job-level timing model.
module tb_shared_timer_arbiter;

    localparam int NREQ = 4;
    localparam int DIV  = 4;
    localparam int CW   = 8;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [CW-1:0]   dly [NREQ];
    logic [NREQ*CW-1:0] delay;
    logic [NREQ-1:0] grant, done;
    logic            busy, tick;

    logic [NREQ-1:0]    req_b;
    logic [NREQ*CW-1:0] delay_b;
    logic [NREQ-1:0]    grant_b, done_b;
    logic               busy_b, tick_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    // job-level model: owner, cycles since grant, and the cycle at which done is due
    int m_own, m_el, m_tgt, m_n, m_ptr;

    assign delay = {dly[3], dly[2], dly[1], dly[0]};

    shared_timer_arbiter #(.NREQ(NREQ), .DIVISOR(DIV), .PRE_W(16), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .delay(delay),
        .grant(grant), .done(done), .busy(busy), .tick(tick)
    );

    shared_timer_arbiter #(.NREQ(NREQ), .DIVISOR(1), .PRE_W(4), .CNT_W(CW)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .req(req_b), .delay(delay_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_own = -1; m_el = 0; m_tgt = 0; m_n = 0; m_ptr = 0;
    endfunction

    function automatic void m_edge();
        bit found;
        int w;
        if (!rst_n) begin
            m_reset();
        end else if (m_own < 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                w = (m_ptr + k) % NREQ;
                if (!found && req[w]) begin
                    found = 1;
                    m_own = w;
                    m_n   = int'(dly[w]);
                    m_tgt = (m_n == 0) ? 1 : m_n * DIV;
                    m_el  = 0;
                end
            end
        end else if (m_el == m_tgt) begin
            m_ptr = (m_own + 1) % NREQ;
            m_own = -1;
        end else if (m_n > 0 && !req[m_own]) begin
            m_ptr = (m_own + 1) % NREQ;
            m_own = -1;
        end else begin
            m_el++;
        end
    endfunction

    function automatic logic [NREQ-1:0] exp_grant();
        return (m_own < 0) ? '0 : NREQ'(1) << m_own;
    endfunction

    function automatic logic [NREQ-1:0] exp_done();
        return (m_own >= 0 && m_el == m_tgt) ? exp_grant() : '0;
    endfunction

    function automatic logic exp_tick();
        return m_own >= 0 && m_n > 0 && m_el > 0 && (m_el % DIV) == 0 && m_el <= m_tgt;
    endfunction

    task automatic check_outs();
        chk("grant", 32'(grant), 32'(exp_grant()));
        chk("done",  32'(done),  32'(exp_done()));
        chk("busy",  32'(busy),  32'(m_own >= 0));
        chk("tick",  32'(tick),  32'(exp_tick()));
    endtask

    task automatic cyc();
        @(posedge clk);
        m_edge();
        cyc_n++;
        #1;
        check_outs();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (done == '0 && lat < 400) begin
            cyc();
            lat++;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int seq [4];
        int nseq;
        logic [NREQ-1:0] prev;
        int lat;

        rst_n = 1'b0;
        req = '0;
        req_b = '0;
        delay_b = '0;
        for (int i = 0; i < NREQ; i++) dly[i] = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc();

        // 1: reset mid-RUN, then a full wait after release
        req[0] = 1'b1; dly[0] = 8'd10;
        cyc();
        chk("t1_grant", 32'(grant), 32'h1);
        repeat (7) cyc();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("t1_rst_grant", 32'(grant), 32'h0);
        chk("t1_rst_done",  32'(done),  32'h0);
        chk("t1_rst_busy",  32'(busy),  32'h0);
        chk("t1_rst_tick",  32'(tick),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("t1_regrant", 32'(grant), 32'h1);
        wait_done("t1_lat", 40);
        req[0] = 1'b0;
        repeat (3) cyc();

        // 2: single request, delay 3
        req[1] = 1'b1; dly[1] = 8'd3;
        cyc();
        chk("t2_grant", 32'(grant), 32'h2);
        wait_done("t2_lat", 12);
        chk("t2_done", 32'(done), 32'h2);
        req[1] = 1'b0;
        cyc();
        chk("t2_release", 32'(grant), 32'h0);
        repeat (2) cyc();

        // 3: three contending requesters from reset
        pulse_reset();
        req = 4'b1101;
        for (int i = 0; i < NREQ; i++) dly[i] = 8'd1;
        nseq = 0;
        prev = '0;
        for (int c = 0; c < 60 && nseq < 4; c++) begin
            cyc();
            if (grant != '0 && grant != prev) begin
                for (int k = 0; k < NREQ; k++) if (grant[k] && nseq < 4) seq[nseq] = k;
                nseq++;
            end
            prev = grant;
        end
        chk("t3_count", 32'(nseq), 32'd4);
        chk("t3_seq0", 32'(seq[0]), 32'd0);
        chk("t3_seq1", 32'(seq[1]), 32'd2);
        chk("t3_seq2", 32'(seq[2]), 32'd3);
        chk("t3_seq3", 32'(seq[3]), 32'd0);
        req = '0;
        repeat (3) cyc();

        // 4: zero delay
        req[2] = 1'b1; dly[2] = 8'd0;
        cyc();
        chk("t4_grant", 32'(grant), 32'h4);
        cyc();
        chk("t4_done", 32'(done), 32'h4);
        req[2] = 1'b0;
        repeat (3) cyc();

        // 5: cancel with a pending requester
        req = 4'b1001; dly[3] = 8'd5; dly[0] = 8'd2;
        cyc();
        chk("t5_grant3", 32'(grant), 32'h8);
        repeat (6) cyc();
        req[3] = 1'b0;
        cyc();
        chk("t5_cancel", 32'(grant), 32'h0);
        chk("t5_nodone", 32'(done), 32'h0);
        cyc();
        chk("t5_grant0", 32'(grant), 32'h1);
        wait_done("t5_lat", 8);
        req[0] = 1'b0;
        repeat (3) cyc();

        // 6: maximum count with a divide-by-one prescaler
        req_b = 4'b0001; delay_b[7:0] = 8'hFF;
        lat = 0;
        while (grant_b == '0 && lat < 10) begin cyc(); lat++; end
        chk("t6_grant", 32'(grant_b), 32'h1);
        lat = 0;
        while (done_b == '0 && lat < 400) begin cyc(); lat++; end
        chk("t6_lat", 32'(lat), 32'd255);
        chk("t6_done", 32'(done_b), 32'h1);
        req_b = '0;
        cyc();
        chk("t6_release", 32'(grant_b), 32'h0);
        repeat (2) cyc();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [NREQ-1:0] dn;
            dn = exp_done();
            for (int r = 0; r < NREQ; r++) begin
                dly[r] = CW'($urandom_range(0, 4));
                if (!req[r]) begin
                    if ($urandom_range(0, 3) == 0) req[r] = 1'b1;
                end else if (dn[r]) begin
                    if ($urandom_range(0, 1) == 0) req[r] = 1'b0;
                end else if (m_own == r && $urandom_range(0, 63) == 0) begin
                    req[r] = 1'b0;
                end
            end
            if (i == 700) pulse_reset();
            cyc();
        end
        req = '0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
